// File: rtl/timer_tick_sched.sv
// timer_tick_sched
//
// Drives the system interval timer and turns its timeouts into per-channel
// tick events for software.
//
// Timer side (this block is the master of the timer's 16-bit slave):
//   - after reset, writes 0x0001 to the timer control register (timeout irq on)
//   - on every tm_irq, writes 0x0000 to the timer status register (clear
//     timeout), waits one cycle for the irq to fall, then processes one tick
//
// Host side (16-bit slave, word addressed):
//   0 GLOBAL_CTRL  bit0 RUN, bit1 IE                      R/W
//   1 PENDING      bits[NUM_CH-1:0], write-1-to-clear     R/W1C
//   2 CH_SEL       bits[2:0], selects the channel below   R/W
//   3 CH_RELOAD    write loads reload and count           R/W
//   4 CH_CTRL      bit0 EN, bit1 ONESHOT                  R/W
//   5 CH_COUNT     current down-count                     RO
//   6 TICK_COUNT   ticks seen since reset (wraps)         RO
//   7 reserved     reads 0, writes ignored
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   address, chipselect, write_n, writedata, readdata   host slave
//                     (reads: readdata is registered, valid the cycle after
//                     chipselect & write_n is presented)
//   irq               IE & |pending
//   tm_address, tm_chipselect, tm_write_n, tm_writedata   timer master
//                     (registered, single-cycle accesses, no waitrequest)
//   tm_irq            timer level interrupt
//   ch_event          one-cycle pulse per channel expiry
//
// Timer handshake: an access is a single cycle with tm_chipselect=1 and
// tm_write_n=0; the timer has no waitrequest so the access always completes
// in that cycle.

module timer_tick_sched #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 16,
  parameter int TMR_STATUS_ADDR = 0,
  parameter int TMR_CTRL_ADDR   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [2:0]        tm_address,
  output logic              tm_chipselect,
  output logic              tm_write_n,
  output logic [15:0]       tm_writedata,
  input  logic              tm_irq,
  output logic [NUM_CH-1:0] ch_event
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_ACK  = 3'd2,
    ST_WAIT = 3'd3,
    ST_TICK = 3'd4
  } state_t;

  state_t state;

  // Host-visible registers
  logic              run;
  logic              ie;
  logic [NUM_CH-1:0] pending;
  logic [2:0]        ch_sel;
  logic [15:0]       tick_count;

  // Channel state
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_oneshot;
  logic [CNT_W-1:0]  ch_count  [NUM_CH];
  logic [CNT_W-1:0]  ch_reload [NUM_CH];

  // Decode
  logic              host_wr;
  logic [NUM_CH-1:0] sel_hit;   // one-hot selected channel, all-zero when CH_SEL >= NUM_CH
  logic [NUM_CH-1:0] ch_wr;     // host writes CH_RELOAD/CH_CTRL of channel i this cycle
  logic [NUM_CH-1:0] w1c_mask;
  logic              tick_upd;
  logic [NUM_CH-1:0] expire;

  // Read mux
  logic [CNT_W-1:0]  sel_reload;
  logic [CNT_W-1:0]  sel_count;
  logic              sel_en;
  logic              sel_oneshot;
  logic [15:0]       rd_data;

  assign host_wr  = chipselect & ~write_n;
  assign tick_upd = (state == ST_TICK) & run;
  assign w1c_mask = (host_wr && address == 3'd1) ? writedata[NUM_CH-1:0] : '0;
  assign irq      = ie & (|pending);

  always_comb begin
    sel_hit = '0;
    ch_wr   = '0;
    expire  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_hit[i] = (ch_sel == 3'(i));
      ch_wr[i]   = host_wr & sel_hit[i] & ((address == 3'd3) | (address == 3'd4));
      // A host write to the same channel in the tick cycle takes precedence,
      // so that channel skips its tick update entirely.
      expire[i]  = tick_upd & ch_en[i] & (ch_count[i] == CNT_W'(1)) & ~ch_wr[i];
    end
  end

  always_comb begin
    sel_reload  = '0;
    sel_count   = '0;
    sel_en      = 1'b0;
    sel_oneshot = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_hit[i]) begin
        sel_reload  = ch_reload[i];
        sel_count   = ch_count[i];
        sel_en      = ch_en[i];
        sel_oneshot = ch_oneshot[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (address)
      3'd0:    rd_data = {14'd0, ie, run};
      3'd1:    rd_data = 16'(pending);
      3'd2:    rd_data = {13'd0, ch_sel};
      3'd3:    rd_data = 16'(sel_reload);
      3'd4:    rd_data = {14'd0, sel_oneshot, sel_en};
      3'd5:    rd_data = 16'(sel_count);
      3'd6:    rd_data = tick_count;
      default: rd_data = '0;
    endcase
  end

  // Host register file and read data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run      <= 1'b0;
      ie       <= 1'b0;
      ch_sel   <= '0;
      pending  <= '0;
      readdata <= '0;
      ch_event <= '0;
    end else begin
      if (host_wr && address == 3'd0) begin
        run <= writedata[0];
        ie  <= writedata[1];
      end
      if (host_wr && address == 3'd2) begin
        ch_sel <= writedata[2:0];
      end
      // Expiry set overrides a simultaneous write-1-to-clear.
      pending  <= (pending & ~w1c_mask) | expire;
      ch_event <= expire;
      readdata <= (chipselect & write_n) ? rd_data : '0;
    end
  end

  // Channel counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_en      <= '0;
      ch_oneshot <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_count[i]  <= '0;
        ch_reload[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_wr[i]) begin
          if (address == 3'd3) begin
            ch_reload[i] <= writedata[CNT_W-1:0];
            ch_count[i]  <= writedata[CNT_W-1:0];
          end else begin
            ch_en[i]      <= writedata[0];
            ch_oneshot[i] <= writedata[1];
          end
        end else if (tick_upd && ch_en[i]) begin
          if (ch_count[i] > CNT_W'(1)) begin
            ch_count[i] <= ch_count[i] - CNT_W'(1);
          end else if (ch_count[i] == CNT_W'(1)) begin
            if (ch_oneshot[i]) begin
              ch_count[i] <= '0;
              ch_en[i]    <= 1'b0;
            end else begin
              ch_count[i] <= ch_reload[i];
            end
          end
          // count == 0 with EN set (reload 0) holds and never fires
        end
      end
    end
  end

  // Timer master FSM; bus outputs are registered so each access is
  // presented in the cycle after the decision is made.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_INIT;
      tick_count    <= '0;
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= '0;
      tm_writedata  <= '0;
    end else begin
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= '0;
      tm_writedata  <= '0;
      case (state)
        ST_INIT: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 3'(TMR_CTRL_ADDR);
          tm_writedata  <= 16'h0001;
          state         <= ST_IDLE;
        end
        ST_IDLE: begin
          if (tm_irq) begin
            tm_chipselect <= 1'b1;
            tm_write_n    <= 1'b0;
            tm_address    <= 3'(TMR_STATUS_ADDR);
            tm_writedata  <= 16'h0000;
            state         <= ST_ACK;
          end
        end
        // Status write is on the bus during this cycle.
        ST_ACK:  state <= ST_WAIT;
        // Timer irq falls during this cycle; it must not be resampled yet.
        ST_WAIT: state <= ST_TICK;
        ST_TICK: begin
          tick_count <= tick_count + 16'd1;
          state      <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: doc/timer_tick_sched.md
Name: timer_tick_sched

Overview:
- Controller for the system interval timer (fixed-period Avalon timer with a 16-bit slave and a level irq).
- Masters the timer's slave port: enables its interrupt after reset, then acknowledges every timeout.
- Fans each timer tick out to NUM_CH software-programmable down-counting channels with per-channel event pulses.
- Host CPU configures channels through a 16-bit Avalon slave; aggregated pending events drive one irq.

Parameters:
- NUM_CH, 4, number of tick channels (1..8).
- CNT_W, 16, channel counter/reload width (<=16).
- TMR_STATUS_ADDR, 0, timer status register word address.
- TMR_CTRL_ADDR, 1, timer control register word address.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- address  in  3  host slave word address.
- chipselect  in  1  host slave select.
- write_n  in  1  host write strobe, active low.
- writedata  in  16  host write data.
- readdata  out  16  host read data, registered, 1-cycle latency.
- irq  out  1  host interrupt = IE & |pending.
- tm_address  out  3  timer slave address.
- tm_chipselect  out  1  timer select.
- tm_write_n  out  1  timer write strobe, active low.
- tm_writedata  out  16  timer write data.
- tm_irq  in  1  timer level interrupt.
- ch_event  out  NUM_CH  one-cycle pulse per channel expiry.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=INIT; all channels disabled, count=0, reload=0; pending=0; GLOBAL_CTRL=0; tick_count=0.
  - Outputs: readdata=0, irq=0, ch_event=0, tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
  - Reset mid-sequence abandons any timer access; the next INIT re-enables the timer irq.
- Timer master: outputs are registered; no waitrequest; each access is exactly one cycle.
- FSM:
  - INIT: drive a write of 0x0001 to TMR_CTRL_ADDR for one cycle -> IDLE.
  - IDLE: tm_irq=1 -> ACK.
  - ACK: write 0x0000 to TMR_STATUS_ADDR (clears timeout) -> WAIT.
  - WAIT: one cycle for the timer irq to drop -> TICK.
  - TICK: tick_count+=1 (16-bit wrap); if RUN=1, update channels -> IDLE.
  - Latency: tm_irq high in IDLE at cycle N -> write on bus at N+1 -> TICK at N+3 -> ch_event at N+4.
  - tm_irq still high when IDLE is re-entered -> ACK again (no tick lost, no extra tick).
- Channel update in TICK, per enabled channel i:
  - count>1: count-1.
  - count==1: expire -> ch_event[i]=1 next cycle; pending[i]=1.
    - Periodic: count=reload.
    - Oneshot: count=0 and enable cleared.
  - count==0 while enabled (reload 0): no change, never fires.
- Host registers (writes when chipselect & ~write_n):
  - 0 GLOBAL_CTRL: bit0 RUN, bit1 IE; R/W.
  - 1 PENDING: bits[NUM_CH-1:0]; read; write-1-to-clear.
  - 2 CH_SEL: bits[2:0]; R/W; values >= NUM_CH ignore channel accesses (read 0).
  - 3 CH_RELOAD: write sets reload and count of the selected channel; reads reload.
  - 4 CH_CTRL: bit0 EN, bit1 ONESHOT; R/W.
  - 5 CH_COUNT: read-only current count.
  - 6 TICK_COUNT: read-only.
  - 7: reads 0; writes ignored.
- Unused read bits are 0.
- Collisions:
  - Expiry set and host W1C of the same pending bit in one cycle -> set wins.
  - Host CH_RELOAD/CH_CTRL write in the TICK cycle for that channel -> host write wins; no expiry that cycle.
- irq is combinational from registers; it drops the cycle after PENDING is cleared or IE=0.

Test Plan:
- Release reset -> cycle 1: tm_address=1, tm_writedata=0x0001, tm_write_n=0, tm_chipselect=1 for exactly 1 cycle; state IDLE afterwards.
- Model timer asserting tm_irq; RUN=1, ch0 reload=3, EN=1 -> status write (addr 0, data 0) 1 cycle after each irq; ch_event[0] on every 3rd tick, 4 cycles after that tick's irq; CH_COUNT sequence 3,2,1,3.
- ch1 reload=2, ONESHOT=1, EN=1, IE=1 -> single ch_event[1] after tick 2; pending=0x0002; irq=1; CH_CTRL EN reads 0; write 0x0002 to PENDING -> irq=0 next cycle.
- RUN=0 with ticks arriving -> timer still acked each tick; TICK_COUNT increments; channel counts frozen; no ch_event.
- W1C of pending[0] in the same cycle as a ch0 expiry -> pending[0] stays 1; CH_RELOAD write in the TICK cycle -> count equals the written value, no event.
- Assert reset_n=0 during WAIT -> outputs return to reset values next cycle; INIT control write repeats after release.
